// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction and data memory handshake bundle for multicycle_ctrl.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;
  modport master(output imem_req, dmem_req, dmem_we, input imem_ack, imem_rdata, dmem_ack);
  modport slave(input imem_req, dmem_req, dmem_we, output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB/HALT controller with PC and retire tracking.
// Define PERF_CNT_EN to make instret count retired instructions; otherwise instret reads 0.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.master mem,
  output logic [31:0] instr,
  input logic op_load,
  input logic op_store,
  input logic op_halt,
  output logic rf_we,
  output logic [31:0] pc,
  output logic [2:0] state,
  output logic retire,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  state_t cur, nxt;
  assign state = cur;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cur <= FETCH;
      pc <= RESET_PC;
      instr <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && mem.imem_ack) instr <= mem.imem_rdata;
      if (retire) pc <= pc + PC_STEP;
    end
  // imem_req is gated by reset so nothing is requested while reset is held
  always_comb begin
    nxt = FETCH;
    mem.imem_req = reset && cur == FETCH;
    mem.dmem_req = cur == MEM;
    mem.dmem_we = cur == MEM && op_store;
    rf_we = cur == WB;
    retire = cur == WB || (cur == MEM && op_store && mem.dmem_ack);
    case (cur)
      FETCH: nxt = mem.imem_ack ? DECODE : FETCH;
      DECODE: nxt = op_halt ? HALT : EXEC;
      EXEC: nxt = (op_load || op_store) ? MEM : WB;
      MEM: nxt = !mem.dmem_ack ? MEM : op_store ? FETCH : WB;
      WB: nxt = FETCH;
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) instret <= '0;
    else if (retire) instret <= instret + 32'd1;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl; the bench acts as memory and decoder.
module tb_multicycle_ctrl;
  localparam logic [31:0] ALU = 32'h0000_1230, LOAD = 32'h0000_4561, STORE = 32'h0000_7892, HALTI = 32'h0000_0003;
  typedef struct {logic [31:0] pc; logic rf;} sb_t;
  logic clk, reset;
  logic [31:0] instr, pc, instret, w_instr, w_pc, w_instret;
  logic [2:0] state, w_state;
  logic rf_we, retire, w_rf_we, w_retire;
  logic op_load, op_store, op_halt;
  int checks = 0, errors = 0, retired = 0;
  logic [31:0] exp_pc;
  sb_t sb[$];
  int st_log[$];
  multicycle_ctrl_if m();
  multicycle_ctrl_if w_if();
  assign op_load = instr[1:0] == 2'd1;
  assign op_store = instr[1:0] == 2'd2;
  assign op_halt = instr[1:0] == 2'd3;
  assign w_if.imem_ack = w_if.imem_req;
  assign w_if.imem_rdata = ALU;
  assign w_if.dmem_ack = 1'b0;
  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .mem(m), .instr(instr), .op_load(op_load), .op_store(op_store),
    .op_halt(op_halt), .rf_we(rf_we), .pc(pc), .state(state), .retire(retire), .instret(instret)
  );
  multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC)) w_dut (
    .clk(clk), .reset(reset), .mem(w_if), .instr(w_instr), .op_load(1'b0), .op_store(1'b0),
    .op_halt(1'b0), .rf_we(w_rf_we), .pc(w_pc), .state(w_state), .retire(w_retire), .instret(w_instret)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic do_reset;
    reset = 0;
    m.imem_ack = 0;
    m.dmem_ack = 0;
    m.imem_rdata = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    exp_pc = 32'h0;
    sb.delete();
    retired = 0;
  endtask
  // Runs one instruction with the given memory wait states and checks latency, handshakes and retire.
  task automatic exec_instr(input logic [31:0] word, input int iw, input int dw);
    int cyc = 0, ni = 0, nd = 0, nrf = 0, nret = 0;
    bit done = 0;
    bit is_load = word[1:0] == 2'd1, is_store = word[1:0] == 2'd2, is_halt = word[1:0] == 2'd3;
    int e_cyc = iw + (is_halt ? 2 : is_store ? 4 + dw : is_load ? 5 + dw : 4);
    sb_t e;
    if (!is_halt) begin
      sb.push_back('{exp_pc, !is_store});
      exp_pc = exp_pc + 32'd4;
    end
    st_log.delete();
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (is_halt && state == 3'd5) done = 1;
      else begin
        cyc++;
        st_log.push_back(int'(state));
        m.imem_rdata = word;
        m.imem_ack = m.imem_req && ni >= iw;
        if (m.imem_req) ni++;
        m.dmem_ack = m.dmem_req && nd >= dw;
        if (m.dmem_req) nd++;
        #1;
        checks++;
        if (m.dmem_req && m.dmem_we !== is_store) begin
          errors++;
          $display("FAIL dmem_we: got %b expected %b", m.dmem_we, is_store);
        end
        checks++;
        if ($countones({m.imem_req, m.dmem_req, rf_we}) > 1) begin
          errors++;
          $display("FAIL exclusive: imem_req=%b dmem_req=%b rf_we=%b expected at most one", m.imem_req, m.dmem_req, rf_we);
        end
        if (rf_we) nrf++;
        if (retire) begin
          nret++;
          done = 1;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got retire expected none");
          end else begin
            e = sb.pop_front();
            if (pc !== e.pc || rf_we !== e.rf) begin
              errors++;
              $display("FAIL retire: got pc=%h rf_we=%b expected pc=%h rf_we=%b", pc, rf_we, e.pc, e.rf);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m.imem_ack = 0;
    m.dmem_ack = 0;
    checks++;
    if (cyc !== e_cyc) begin errors++; $display("FAIL latency %h: got %0d expected %0d", word, cyc, e_cyc); end
    checks++;
    if (ni !== iw + 1) begin errors++; $display("FAIL imem_req_cycles: got %0d expected %0d", ni, iw + 1); end
    checks++;
    if (nd !== ((is_load || is_store) ? dw + 1 : 0)) begin errors++; $display("FAIL dmem_req_cycles: got %0d expected %0d", nd, (is_load || is_store) ? dw + 1 : 0); end
    checks++;
    if (nrf !== ((is_halt || is_store) ? 0 : 1)) begin errors++; $display("FAIL rf_we_cycles: got %0d expected %0d", nrf, (is_halt || is_store) ? 0 : 1); end
    checks++;
    if (nret !== (is_halt ? 0 : 1)) begin errors++; $display("FAIL retire_count: got %0d expected %0d", nret, is_halt ? 0 : 1); end
    checks++;
    if (instr !== word) begin errors++; $display("FAIL instr: got %h expected %h", instr, word); end
    checks++;
    if (pc !== exp_pc) begin errors++; $display("FAIL pc_after: got %h expected %h", pc, exp_pc); end
    retired += nret;
    checks++;
`ifdef PERF_CNT_EN
    if (instret !== 32'(retired)) begin errors++; $display("FAIL instret: got %0d expected %0d", instret, retired); end
`else
    if (instret !== 32'd0) begin errors++; $display("FAIL instret: got %0d expected 0", instret); end
`endif
  endtask
  task automatic test_reset;
    reset = 0;
    m.imem_ack = 1;
    m.dmem_ack = 1;
    m.imem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({state, pc, instr, m.imem_req, m.dmem_req, m.dmem_we, rf_we, retire, instret} !== '0) begin
      errors++;
      $display("FAIL reset: got state=%0d pc=%h instr=%h reqs=%b%b%b rf_we=%b retire=%b expected all 0",
               state, pc, instr, m.imem_req, m.dmem_req, m.dmem_we, rf_we, retire);
    end
  endtask
  task automatic test_alu;
    do_reset();
    exec_instr(ALU, 0, 0);
    checks++;
    if (st_log.size() != 4 || st_log[0] != 0 || st_log[1] != 1 || st_log[2] != 2 || st_log[3] != 4 || state !== 3'd0) begin
      errors++;
      $display("FAIL alu_states: got %p then %0d expected 0 1 2 4 then 0", st_log, state);
    end
  endtask
  task automatic test_load;
    exec_instr(LOAD, 3, 2);
  endtask
  task automatic test_store;
    exec_instr(STORE, 1, 1);
    exec_instr(STORE, 0, 0);
  endtask
  task automatic test_halt;
    logic [31:0] p, ins;
    do_reset();
    exec_instr(ALU, 0, 0);
    exec_instr(HALTI, 1, 0);
    p = pc;
    ins = instr;
    repeat (10) begin
      @(negedge clk);
      m.imem_ack = 1;
      m.dmem_ack = 1;
      m.imem_rdata = 32'hDEAD_BEE0;
      #1;
      checks++;
      if ({m.imem_req, m.dmem_req, m.dmem_we, rf_we, retire} !== '0 || pc !== p || instr !== ins || state !== 3'd5) begin
        errors++;
        $display("FAIL halt_hold: got state=%0d pc=%h instr=%h outs=%b expected state=5 pc=%h instr=%h outs=0",
                 state, pc, instr, {m.imem_req, m.dmem_req, m.dmem_we, rf_we, retire}, p, ins);
      end
    end
    m.imem_ack = 0;
    m.dmem_ack = 0;
  endtask
  task automatic test_reset_mid;
    int n = 0;
    do_reset();
    exec_instr(ALU, 0, 0);
    while (state !== 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
      m.imem_rdata = LOAD;
      m.imem_ack = m.imem_req;
      m.dmem_ack = 0;
    end
    m.imem_ack = 0;
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL reach_mem: got state=%0d expected 3", state); end
    #2 reset = 0;
    #1;
    checks++;
    if ({m.dmem_req, m.imem_req, rf_we, retire} !== '0 || pc !== 32'h0 || state !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d pc=%h dmem_req=%b imem_req=%b retire=%b expected state=0 pc=0 all 0",
               state, pc, m.dmem_req, m.imem_req, retire);
    end
    @(posedge clk);
    #1 reset = 1;
    exp_pc = 32'h0;
    sb.delete();
    retired = 0;
    exec_instr(ALU, 0, 0);
  endtask
  task automatic test_back_to_back;
    do_reset();
    exec_instr(ALU, 0, 0);
    exec_instr(LOAD, 0, 0);
    exec_instr(STORE, 0, 0);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
  endtask
  task automatic test_wrap;
    int n = 0;
    do_reset();
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (w_retire) break;
    end
    checks++;
    if (w_retire !== 1'b1 || n !== 4 || w_pc !== 32'hFFFF_FFFC || w_state !== 3'd4 || w_instr !== ALU || {w_if.dmem_req, w_if.dmem_we} !== 2'b0) begin
      errors++;
      $display("FAIL wrap_retire: got retire=%b cycle=%0d pc=%h state=%0d expected 1 4 fffffffc 4", w_retire, n, w_pc, w_state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (w_pc !== 32'h0 || w_rf_we !== 1'b0) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", w_pc); end
    checks++;
`ifdef PERF_CNT_EN
    if (w_instret !== 32'd1) begin errors++; $display("FAIL wrap_instret: got %0d expected 1", w_instret); end
`else
    if (w_instret !== 32'd0) begin errors++; $display("FAIL wrap_instret: got %0d expected 0", w_instret); end
`endif
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, PC increment per retired instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_ack  input  1  instruction memory response; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  latched instruction register, to the decoder and register-file index fields.
REQ-009 op_load, op_store, op_halt  input  1 each  decoder class flags derived combinationally from instr; mutually exclusive.
REQ-010 dmem_req  output  1  data memory request.
REQ-011 dmem_we  output  1  data memory write enable; 1 = store.
REQ-012 dmem_ack  input  1  data memory response.
REQ-013 rf_we  output  1  register-file write enable to the datapath.
REQ-014 pc  output  32  current program counter.
REQ-015 state  output  3  FSM state encoding per REQ-017.
REQ-016 retire  output  1  one-cycle pulse per completed instruction.

Function
REQ-017 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL transition to FETCH next cycle with no outputs asserted.
REQ-018 FETCH SHALL hold imem_req=1 until imem_ack=1; on ack, instr <= imem_rdata, go to DECODE; ack in the same cycle as first req SHALL be accepted.
REQ-019 DECODE SHALL last one cycle: op_halt -> HALT, else -> EXEC.
REQ-020 EXEC SHALL last one cycle: op_load or op_store -> MEM, else -> WB.
REQ-021 MEM SHALL hold dmem_req=1, dmem_we=op_store until dmem_ack=1; on ack, load -> WB; store -> FETCH with pc <= pc+PC_STEP and retire=1.
REQ-022 WB SHALL assert rf_we=1 for exactly one cycle, pc <= pc+PC_STEP, retire=1, then go to FETCH.
REQ-023 HALT SHALL be terminal until reset; all request/enable outputs 0, pc frozen.
REQ-024 Latency with zero-wait memories SHALL be: ALU 4 cycles, load 5, store 4, halt 2 then idle.
REQ-025 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-026 PC addition SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-027 rf_we, dmem_req, imem_req SHALL never be asserted in the same cycle.
REQ-028 instr SHALL change only on FETCH acknowledge.

Reset
REQ-029 Reset low SHALL immediately force state=FETCH, pc=RESET_PC, instr=0, imem_req=0 while held, dmem_req=dmem_we=rf_we=retire=0.
REQ-030 Reset mid-transaction SHALL abandon the pending request with no retire; fetch from RESET_PC SHALL begin on the first edge after release.

Configuration
REQ-031 With PERF_CNT_EN defined: output instret (32) SHALL count retire pulses, reset to 0, wrap 32'hFFFF_FFFF -> 0; without it, the instret port SHALL exist and read constant 0.

Verification
REQ-032 ALU instr, acks same cycle as req -> states 0,1,2,4,0; rf_we for 1 cycle; pc 0 -> 4; retire once.
REQ-033 Load, imem_ack delayed 3 cycles, dmem_ack delayed 2 -> imem_req high 4 cycles, dmem_req high 3 cycles with dmem_we=0, rf_we once, pc +4.
REQ-034 Store -> dmem_we=1 while dmem_req; no rf_we; retire at MEM ack; pc +4.
REQ-035 Halt instr -> state 5 after DECODE; stray acks for 10 cycles: pc, instr, outputs unchanged.
REQ-036 Reset low during MEM wait -> dmem_req drops asynchronously; pc=RESET_PC; no retire; fetch restarts.
REQ-037 pc preset near 32'hFFFF_FFFC via RESET_PC, ALU instr -> pc 0; with PERF_CNT_EN, 3 instrs -> instret=3.
